// File: rtl/onehot_decoder.sv
// onehot_decoder: registered binary-to-one-hot decoder.
// Ports:
//   clk, rst_n   : rising-edge clock, async active-low reset
//   en           : sample enable for a
//   a [BITS]     : binary index to decode
//   b [2**BITS]  : registered one-hot result, bit a set
//   valid        : high for the cycle after each enabled sample
//   onehot_err   : sticky popcount(b) > 1 flag
//                  (only with ONEHOT_DECODER_CHECK_EN defined)
module onehot_decoder #(
    parameter  int BITS  = 2,
    localparam int OUT_W = 2 ** BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [BITS-1:0]  a,
    output logic [OUT_W-1:0] b,
    output logic             valid
`ifdef ONEHOT_DECODER_CHECK_EN
    ,
    output logic             onehot_err
`endif
);

    generate
        if (BITS < 1 || BITS > 8) begin : g_bits_range
            $error("onehot_decoder: BITS must be within 1..8");
        end
    endgenerate

    logic [OUT_W-1:0] dec;

    always_comb begin
        dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec[i] = (a == BITS'(i));
        end
    end

    // b holds its last word while en is low; only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                b <= dec;
            end
        end
    end

`ifdef ONEHOT_DECODER_CHECK_EN
    localparam int CNT_W = $clog2(OUT_W + 1);

    function automatic logic [CNT_W-1:0] popcount(
        input logic [OUT_W-1:0] v
    );
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    logic multi_hot;

    // All-zeros is legal (post-reset), so only two or more set bits flag.
    assign multi_hot = (popcount(b) > CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else if (multi_hot) begin
            onehot_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// tb_onehot_decoder: self-checking bench for onehot_decoder.
// Drives a BITS=2 and a BITS=4 instance from tables and random streams.
module tb_onehot_decoder;

    logic        clk;
    logic        rst_n;
    logic        en2;
    logic [1:0]  a2;
    logic [3:0]  b2;
    logic        v2;
    logic        en4;
    logic [3:0]  a4;
    logic [15:0] b4;
    logic        v4;
`ifdef ONEHOT_DECODER_CHECK_EN
    logic        err2;
    logic        err4;
`endif

    int checks = 0;
    int passes = 0;

    logic [4:0]  q2[$];
    logic [16:0] q4[$];

    typedef struct {
        logic       e;
        logic [1:0] a;
        logic [3:0] b;
        logic       v;
    } vec2_t;

    typedef struct {
        logic        e;
        logic [3:0]  a;
        logic [15:0] b;
        logic        v;
    } vec4_t;

    onehot_decoder #(.BITS(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en2),
        .a     (a2),
        .b     (b2),
        .valid (v2)
`ifdef ONEHOT_DECODER_CHECK_EN
        ,
        .onehot_err (err2)
`endif
    );

    onehot_decoder #(.BITS(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en4),
        .a     (a4),
        .b     (b4),
        .valid (v4)
`ifdef ONEHOT_DECODER_CHECK_EN
        ,
        .onehot_err (err4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(
        input string       name,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step2(
        input logic       e,
        input logic [1:0] x,
        input logic [3:0] eb,
        input logic       ev
    );
        logic [4:0] exp;
        @(negedge clk);
        en2 = e;
        a2  = x;
        q2.push_back({ev, eb});
        @(posedge clk);
        #1;
        if (q2.size() == 0) begin
            check("q2_underflow", 1, 0);
        end else begin
            exp = q2.pop_front();
            check("b2", 32'(b2), 32'(exp[3:0]));
            check("valid2", 32'(v2), 32'(exp[4]));
        end
    endtask

    task automatic step4(
        input logic        e,
        input logic [3:0]  x,
        input logic [15:0] eb,
        input logic        ev
    );
        logic [16:0] exp;
        @(negedge clk);
        en4 = e;
        a4  = x;
        q4.push_back({ev, eb});
        @(posedge clk);
        #1;
        if (q4.size() == 0) begin
            check("q4_underflow", 1, 0);
        end else begin
            exp = q4.pop_front();
            check("b4", 32'(b4), 32'(exp[15:0]));
            check("valid4", 32'(v4), 32'(exp[16]));
            if (exp[16]) begin
                check("pop4", 32'($countones(b4)), 1);
            end
        end
    endtask

    vec2_t t2[8];
    vec4_t t4[6];

    initial begin
        logic [15:0] one;
        logic [3:0]  x;

        t2[0] = '{1'b1, 2'd0, 4'b0001, 1'b1};
        t2[1] = '{1'b1, 2'd1, 4'b0010, 1'b1};
        t2[2] = '{1'b1, 2'd2, 4'b0100, 1'b1};
        t2[3] = '{1'b1, 2'd3, 4'b1000, 1'b1};
        t2[4] = '{1'b0, 2'd1, 4'b1000, 1'b0};
        t2[5] = '{1'b0, 2'd1, 4'b1000, 1'b0};
        t2[6] = '{1'b0, 2'd1, 4'b1000, 1'b0};
        t2[7] = '{1'b1, 2'd1, 4'b0010, 1'b1};

        t4[0] = '{1'b1, 4'd0,  16'h0001, 1'b1};
        t4[1] = '{1'b1, 4'd2,  16'h0004, 1'b1};
        t4[2] = '{1'b1, 4'd5,  16'h0020, 1'b1};
        t4[3] = '{1'b1, 4'd15, 16'h8000, 1'b1};
        t4[4] = '{1'b0, 4'd3,  16'h8000, 1'b0};
        t4[5] = '{1'b1, 4'd5,  16'h0020, 1'b1};

        rst_n = 1'b0;
        en2   = 1'b0;
        a2    = '0;
        en4   = 1'b0;
        a4    = '0;
        one   = 16'h0001;

        #2;
        check("rst_b2", 32'(b2), 0);
        check("rst_v2", 32'(v2), 0);
        check("rst_b4", 32'(b4), 0);
        check("rst_v4", 32'(v4), 0);

        @(negedge clk);
        rst_n = 1'b1;

        step2(1'b0, 2'd2, 4'b0000, 1'b0);
        step4(1'b0, 4'd9, 16'h0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step2(t2[i].e, t2[i].a, t2[i].b, t2[i].v);
        end
        for (int i = 0; i < 6; i++) begin
            step4(t4[i].e, t4[i].a, t4[i].b, t4[i].v);
        end

        // b4 is 16'h0020 here; reset lands between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_b4", 32'(b4), 0);
        check("midrst_v4", 32'(v4), 0);
        check("midrst_b2", 32'(b2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step4(1'b1, 4'd7, 16'h0080, 1'b1);

        for (int i = 0; i < 200; i++) begin
            x = 4'($urandom_range(0, 15));
            step4(1'b1, x, one << x, 1'b1);
        end
        step4(1'b0, 4'd0, b4, 1'b0);

`ifdef ONEHOT_DECODER_CHECK_EN
        check("err2_idle", 32'(err2), 0);
        check("err4_idle", 32'(err4), 0);
        @(negedge clk);
        en4 = 1'b0;
        force u4.b = 16'h0011;
        @(posedge clk);
        #1;
        check("err4_set", 32'(err4), 1);
        release u4.b;
        step4(1'b1, 4'd3, 16'h0008, 1'b1);
        step4(1'b1, 4'd4, 16'h0010, 1'b1);
        check("err4_sticky", 32'(err4), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("err4_clr", 32'(err4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step4(1'b1, 4'd1, 16'h0002, 1'b1);
        check("err4_after", 32'(err4), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
